// File: rtl/div_iter_hs_if.sv
// div_iter_hs_if: request/result bundle for the iterative divider.
// The master side issues operations and consumes results; the slave side is the divider.
// dbg_state mirrors the divider FSM state (IDLE=0, BUSY=1, FIX=2, DONE=3).
interface div_iter_hs_if #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic             div_signed;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic [TAG_W-1:0] in_tag;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] r;
   logic             div_zero;
   logic [TAG_W-1:0] out_tag;
   logic [1:0]       dbg_state;

   modport master (
      output in_valid, div_signed, x, y, in_tag, flush, out_ready,
      input  in_ready, out_valid, s, r, div_zero, out_tag, dbg_state
   );

   modport slave (
      input  in_valid, div_signed, x, y, in_tag, flush, out_ready,
      output in_ready, out_valid, s, r, div_zero, out_tag, dbg_state
   );
endinterface

// File: rtl/div_iter_hs.sv
// div_iter_hs: iterative restoring divider (signed/unsigned) with valid/ready
// handshakes on request and result, flush, tag passthrough and zero-bubble
// back-to-back issue. One quotient bit per cycle; result WIDTH+1 cycles after accept.
// Optional macro DIV_ZERO_FAST_EN: a divide-by-zero accept skips the iteration and
// presents its result one cycle after accept.
//
// Handshake: a transfer happens on a rising div_clk edge where valid & ready are
// both high; valid never depends on ready, and once out_valid is high the result
// (s, r, div_zero, out_tag) holds until the transfer or a flush.
module div_iter_hs #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
) (
   input logic        div_clk,
   input logic        reset,
   div_iter_hs_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);

   state_t state_q, state_d;

   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] dvd_q;      // dividend bits shift out, quotient bits shift in
   logic [WIDTH-1:0] dsr_q;      // |y|
   logic [WIDTH:0]   rem_q;      // partial remainder
   logic [WIDTH-1:0] x_raw_q;
   logic             q_neg_q, r_neg_q, zero_q;
   logic [TAG_W-1:0] tag_q;

   logic [WIDTH-1:0] s_q, r_q;
   logic             div_zero_q;
   logic [TAG_W-1:0] out_tag_q;

   logic             in_ready, accept, fast_zero;
   logic             x_neg, y_neg, y_is_zero;
   logic [WIDTH-1:0] x_abs, y_abs;
   logic [WIDTH+1:0] rem_shift, trial;
   logic             borrow;
   logic [WIDTH:0]   rem_next;
   logic [WIDTH-1:0] rem_mag, s_fix, r_fix;

   // Request side decode: readiness, operand magnitudes and signs
   always_comb begin
      in_ready  = ((state_q == IDLE) | ((state_q == DONE) & bus.out_ready)) & ~bus.flush;
      accept    = bus.in_valid & in_ready;
      x_neg     = bus.div_signed & bus.x[WIDTH-1];
      y_neg     = bus.div_signed & bus.y[WIDTH-1];
      y_is_zero = (bus.y == '0);
      x_abs     = x_neg ? (~bus.x + ONE_W) : bus.x;
      y_abs     = y_neg ? (~bus.y + ONE_W) : bus.y;
`ifdef DIV_ZERO_FAST_EN
      fast_zero = accept & y_is_zero;
`else
      fast_zero = 1'b0;
`endif
   end

   // One restoring step and the final sign correction
   always_comb begin
      rem_shift = {rem_q, dvd_q[WIDTH-1]};
      trial     = rem_shift - {2'b00, dsr_q};
      borrow    = trial[WIDTH+1];
      rem_next  = borrow ? rem_shift[WIDTH:0] : trial[WIDTH:0];
      rem_mag   = rem_q[WIDTH-1:0];
      s_fix     = zero_q ? '1      : (q_neg_q ? (~dvd_q + ONE_W)   : dvd_q);
      r_fix     = zero_q ? x_raw_q : (r_neg_q ? (~rem_mag + ONE_W) : rem_mag);
   end

   // FSM state register
   always_ff @(posedge div_clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // FSM next-state logic; flush abandons whatever is in flight
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = fast_zero ? DONE : BUSY;
         BUSY: begin
            if (bus.flush)              state_d = IDLE;
            else if (cnt_q == CNT_LAST) state_d = FIX;
         end
         FIX:  state_d = bus.flush ? IDLE : DONE;
         DONE: begin
            if (bus.flush)          state_d = IDLE;
            else if (accept)        state_d = fast_zero ? DONE : BUSY;
            else if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Operand capture on accept, then one quotient bit per BUSY cycle
   always_ff @(posedge div_clk or posedge reset) begin
      if (reset) begin
         cnt_q   <= '0;
         dvd_q   <= '0;
         dsr_q   <= '0;
         rem_q   <= '0;
         x_raw_q <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
         zero_q  <= 1'b0;
         tag_q   <= '0;
      end else if (accept) begin
         cnt_q   <= '0;
         dvd_q   <= x_abs;
         dsr_q   <= y_abs;
         rem_q   <= '0;
         x_raw_q <= bus.x;
         q_neg_q <= bus.div_signed & (bus.x[WIDTH-1] ^ bus.y[WIDTH-1]);
         r_neg_q <= x_neg;
         zero_q  <= y_is_zero;
         tag_q   <= bus.in_tag;
      end else if (state_q == BUSY) begin
         cnt_q   <= cnt_q + CNT_W'(1);
         dvd_q   <= {dvd_q[WIDTH-2:0], ~borrow};
         rem_q   <= rem_next;
      end
   end

   // Result registers: written in FIX (or directly on a fast zero-divide accept)
   always_ff @(posedge div_clk or posedge reset) begin
      if (reset) begin
         s_q        <= '0;
         r_q        <= '0;
         div_zero_q <= 1'b0;
         out_tag_q  <= '0;
      end else if (fast_zero) begin
         s_q        <= '1;
         r_q        <= bus.x;
         div_zero_q <= 1'b1;
         out_tag_q  <= bus.in_tag;
      end else if (state_q == FIX) begin
         s_q        <= s_fix;
         r_q        <= r_fix;
         div_zero_q <= zero_q;
         out_tag_q  <= tag_q;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = (state_q == DONE);
   assign bus.s         = s_q;
   assign bus.r         = r_q;
   assign bus.div_zero  = div_zero_q;
   assign bus.out_tag   = out_tag_q;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_div_iter_hs.sv
// tb_div_iter_hs: directed bench for div_iter_hs (WIDTH=32 and WIDTH=8 instances).
module tb_div_iter_hs;

`ifdef DIV_ZERO_FAST_EN
   localparam int ZLAT32 = 1;
`else
   localparam int ZLAT32 = 33;
`endif

   logic div_clk = 1'b0;
   logic reset   = 1'b1;
   int   total   = 0;
   int   bad     = 0;

   div_iter_hs_if #(.WIDTH(32), .TAG_W(4)) bus  ();
   div_iter_hs_if #(.WIDTH(8),  .TAG_W(4)) bus8 ();

   div_iter_hs #(.WIDTH(32), .TAG_W(4)) u_dut32 (.div_clk(div_clk), .reset(reset), .bus(bus));
   div_iter_hs #(.WIDTH(8),  .TAG_W(4)) u_dut8  (.div_clk(div_clk), .reset(reset), .bus(bus8));

   // clock
   always #5 div_clk = ~div_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // ---- WIDTH=32 driver tasks ----
   task automatic issue32(input bit sg, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] t);
      bus.in_valid = 1'b1; bus.div_signed = sg; bus.x = a; bus.y = b; bus.in_tag = t;
      @(negedge div_clk);
      chk("issue32.in_ready", bus.in_ready, 1);
      @(posedge div_clk); #1;
      bus.in_valid = 1'b0; bus.x = '0; bus.y = '0; bus.in_tag = '0;
   endtask

   task automatic wait_valid32(output int lat);
      lat = 0;
      do begin
         @(posedge div_clk); #1;
         lat++;
      end while (!bus.out_valid && lat < 200);
   endtask

   task automatic consume32();
      bus.out_ready = 1'b1;
      @(posedge div_clk); #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic run32(input string nm, input bit sg, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] t, input int elat,
                        input logic [31:0] es, input logic [31:0] er, input bit edz);
      int lat;
      issue32(sg, a, b, t);
      wait_valid32(lat);
      chk({nm, ".lat"}, lat, elat);
      chk({nm, ".s"}, bus.s, es);
      chk({nm, ".r"}, bus.r, er);
      chk({nm, ".dz"}, bus.div_zero, edz);
      chk({nm, ".tag"}, bus.out_tag, t);
      consume32();
      chk({nm, ".idle"}, bus.out_valid, 0);
   endtask

   // ---- WIDTH=8 driver task ----
   task automatic run8(input string nm, input bit sg, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] es, input logic [7:0] er);
      int lat;
      bus8.in_valid = 1'b1; bus8.div_signed = sg; bus8.x = a; bus8.y = b; bus8.in_tag = 4'h5;
      @(negedge div_clk);
      chk({nm, ".in_ready"}, bus8.in_ready, 1);
      @(posedge div_clk); #1;
      bus8.in_valid = 1'b0;
      lat = 0;
      do begin
         @(posedge div_clk); #1;
         lat++;
      end while (!bus8.out_valid && lat < 100);
      chk({nm, ".lat"}, lat, 9);
      chk({nm, ".s"}, bus8.s, es);
      chk({nm, ".r"}, bus8.r, er);
      chk({nm, ".tag"}, bus8.out_tag, 4'h5);
      bus8.out_ready = 1'b1;
      @(posedge div_clk); #1;
      bus8.out_ready = 1'b0;
   endtask

   initial begin
      int  lat;
      bit  ok;
      bit  seen;

      bus.in_valid = 0; bus.div_signed = 0; bus.x = '0; bus.y = '0; bus.in_tag = '0;
      bus.flush = 0; bus.out_ready = 0;
      bus8.in_valid = 0; bus8.div_signed = 0; bus8.x = '0; bus8.y = '0; bus8.in_tag = '0;
      bus8.flush = 0; bus8.out_ready = 0;

      // reset state
      @(negedge div_clk);
      chk("rst.in_ready", bus.in_ready, 1);
      chk("rst.out_valid", bus.out_valid, 0);
      chk("rst.s", bus.s, 0);
      chk("rst.r", bus.r, 0);
      chk("rst.dz", bus.div_zero, 0);
      chk("rst.tag", bus.out_tag, 0);
      chk("rst.state", bus.dbg_state, 0);
      @(posedge div_clk); #1;
      reset = 1'b0;

      // basic results
      run32("u7_2",    0, 32'd7,        32'd2,        4'd3, 33,     32'd3,        32'd1,        0);
      run32("s-7_2",   1, 32'hFFFFFFF9, 32'd2,        4'd5, 33,     32'hFFFFFFFD, 32'hFFFFFFFF, 0);
      run32("s7_-2",   1, 32'd7,        32'hFFFFFFFE, 4'd6, 33,     32'hFFFFFFFD, 32'd1,        0);
      run32("smin_-1", 1, 32'h80000000, 32'hFFFFFFFF, 4'd7, 33,     32'h80000000, 32'd0,        0);
      run32("umax_16", 0, 32'hFFFFFFFF, 32'h10,       4'd8, 33,     32'h0FFFFFFF, 32'hF,        0);
      run32("u5_0",    0, 32'd5,        32'd0,        4'd1, ZLAT32, 32'hFFFFFFFF, 32'd5,        1);
      run32("s-7_0",   1, 32'hFFFFFFF9, 32'd0,        4'd2, ZLAT32, 32'hFFFFFFFF, 32'hFFFFFFF9, 1);

      // hold result under back-pressure, then zero-bubble back-to-back
      issue32(0, 32'd20, 32'd6, 4'd9);
      wait_valid32(lat);
      chk("hold.lat", lat, 33);
      ok = 1'b1;
      repeat (10) begin
         @(posedge div_clk); #1;
         if (!(bus.out_valid === 1'b1 && bus.in_ready === 1'b0 && bus.s === 32'd3 &&
               bus.r === 32'd2 && bus.out_tag === 4'd9)) ok = 1'b0;
      end
      chk("hold.stable", ok, 1);
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1; bus.div_signed = 1'b0; bus.x = 32'd100; bus.y = 32'd7; bus.in_tag = 4'd4;
      @(negedge div_clk);
      chk("b2b.in_ready", bus.in_ready, 1);
      @(posedge div_clk); #1;
      bus.out_ready = 1'b0; bus.in_valid = 1'b0;
      chk("b2b.state", bus.dbg_state, 1);
      wait_valid32(lat);
      chk("b2b.lat", lat, 33);
      chk("b2b.s", bus.s, 14);
      chk("b2b.r", bus.r, 2);
      chk("b2b.tag", bus.out_tag, 4);

      // flush while DONE drops the pending result
      bus.flush = 1'b1;
      @(posedge div_clk); #1;
      bus.flush = 1'b0;
      chk("flush_done.out_valid", bus.out_valid, 0);
      chk("flush_done.state", bus.dbg_state, 0);

      // flush while BUSY, then flush beats in_valid in IDLE
      issue32(0, 32'd1000, 32'd3, 4'd6);
      repeat (10) @(posedge div_clk);
      #1;
      bus.flush = 1'b1;
      @(posedge div_clk); #1;
      bus.flush = 1'b0;
      chk("flush_busy.state", bus.dbg_state, 0);
      @(negedge div_clk);
      chk("flush_busy.in_ready", bus.in_ready, 1);
      @(posedge div_clk); #1;
      bus.flush = 1'b1; bus.in_valid = 1'b1; bus.x = 32'd9; bus.y = 32'd3;
      @(negedge div_clk);
      chk("flush_wins.in_ready", bus.in_ready, 0);
      @(posedge div_clk); #1;
      bus.flush = 1'b0; bus.in_valid = 1'b0;
      chk("flush_wins.state", bus.dbg_state, 0);
      seen = 1'b0;
      repeat (40) begin
         @(posedge div_clk); #1;
         if (bus.out_valid !== 1'b0) seen = 1'b1;
      end
      chk("flush.no_valid", seen, 0);
      run32("u9_3", 0, 32'd9, 32'd3, 4'd10, 33, 32'd3, 32'd0, 0);

      // asynchronous reset mid-operation
      issue32(0, 32'd50, 32'd5, 4'd2);
      repeat (5) @(posedge div_clk);
      #1;
      reset = 1'b1;
      #1;
      chk("arst.out_valid", bus.out_valid, 0);
      chk("arst.in_ready", bus.in_ready, 1);
      chk("arst.s", bus.s, 0);
      chk("arst.r", bus.r, 0);
      chk("arst.state", bus.dbg_state, 0);
      @(posedge div_clk); #1;
      reset = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(posedge div_clk); #1;
         if (bus.out_valid !== 1'b0) seen = 1'b1;
      end
      chk("arst.no_valid", seen, 0);

      // WIDTH=8 instance
      run8("w8_200_7",  0, 8'd200, 8'd7,   8'd28,  8'd4);
      run8("w8_156_7",  0, 8'h9C,  8'd7,   8'h16,  8'h02);
      run8("w8_s-100_7", 1, 8'h9C, 8'd7,   8'hF2,  8'hFE);
      run8("w8_smin_-1", 1, 8'h80, 8'hFF,  8'h80,  8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
